// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift a byte out on
// device-generated clocks, then check the device ACK. Open-drain via output enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR,
  output logic       RX_INHIBIT,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output logic [2:0] DBG_STATE
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FW      = $clog2(FILTER_LEN + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] FLT_ONE  = FW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_REQ     = 3'd2,
    S_SEND    = 3'd3,
    S_ACK     = 3'd4,
    S_WAIT    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t        r_state;
  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_clk_f;
  logic          r_dat_f;
  logic [FW-1:0] r_clk_fcnt;
  logic [FW-1:0] r_dat_fcnt;
  logic          r_fall;
  logic [9:0]    r_shift;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_clk_oe;
  logic          r_data_oe;

  assign TX_BUSY     = r_busy;
  assign RX_INHIBIT  = r_busy;
  assign TX_DONE     = r_done;
  assign TX_ERR      = r_err;
  assign PS2_CLK_OE  = r_clk_oe;
  assign PS2_DATA_OE = r_data_oe;
  assign DBG_STATE   = r_state;

  // Idle bus level is high, so synchronizers and filters reset to 1.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
    end else begin
      r_clk_s <= {r_clk_s[0], PS2_CLK_IN};
      r_dat_s <= {r_dat_s[0], PS2_DATA_IN};
    end
  end

  // A level change is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_clk_f    <= 1'b1;
      r_clk_fcnt <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_clk_s[1] == r_clk_f) begin
        r_clk_fcnt <= '0;
      end else if (r_clk_fcnt == FLT_LAST) begin
        r_clk_f    <= r_clk_s[1];
        r_clk_fcnt <= '0;
        r_fall     <= r_clk_f;
      end else begin
        r_clk_fcnt <= r_clk_fcnt + FLT_ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_dat_f    <= 1'b1;
      r_dat_fcnt <= '0;
    end else if (r_dat_s[1] == r_dat_f) begin
      r_dat_fcnt <= '0;
    end else if (r_dat_fcnt == FLT_LAST) begin
      r_dat_f    <= r_dat_s[1];
      r_dat_fcnt <= '0;
    end else begin
      r_dat_fcnt <= r_dat_fcnt + FLT_ONE;
    end
  end

  // r_cnt counts inhibit time in INHIBIT and cycles since the last device fall afterwards.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (TX_START) begin
            r_shift   <= {1'b1, ~^TX_DATA, TX_DATA};
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_clk_oe  <= 1'b1;
            r_data_oe <= 1'b0;
            r_state   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_cnt == INH_LAST) begin
            r_data_oe <= 1'b1;
            r_state   <= S_REQ;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_REQ: begin
          r_clk_oe  <= 1'b0;
          r_cnt     <= '0;
          r_bit_cnt <= '0;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (r_fall) begin
            r_data_oe <= ~r_shift[0];
            r_shift   <= {1'b1, r_shift[9:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_cnt     <= '0;
            if (r_bit_cnt == 4'd9) r_state <= S_ACK;
          end else if (r_cnt == TO_LAST) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= S_ERR;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_ACK: begin
          if (r_fall) begin
            r_cnt <= '0;
            if (!r_dat_f) begin
              r_state <= S_WAIT;
            end else begin
              r_clk_oe  <= 1'b0;
              r_data_oe <= 1'b0;
              r_state   <= S_ERR;
            end
          end else if (r_cnt == TO_LAST) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= S_ERR;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_WAIT: begin
          if (r_clk_f && r_dat_f) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_fall) begin
            r_cnt <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= S_ERR;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_ERR: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_err     <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a keyboard model clocks frames out of the DUT,
// checks every line bit against an expected queue, and answers (or withholds) ACK.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 200;
  localparam int HALF = 50;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err, rx_inhibit;
  logic       clk_oe, data_oe;
  logic [2:0] dbg_state;
  logic       ps2_clk_in, ps2_data_in;

  // Keyboard model: open-drain wired-AND with the DUT enables
  logic model_clk = 1'b1;
  logic model_low = 1'b0;
  logic glitch = 1'b0;
  assign ps2_clk_in  = ~clk_oe & model_clk & ~glitch;
  assign ps2_data_in = ~data_oe & ~model_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(8)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .TX_DATA(tx_data),
    .TX_START(tx_start),
    .TX_BUSY(tx_busy),
    .TX_DONE(tx_done),
    .TX_ERR(tx_err),
    .RX_INHIBIT(rx_inhibit),
    .PS2_CLK_IN(ps2_clk_in),
    .PS2_DATA_IN(ps2_data_in),
    .PS2_CLK_OE(clk_oe),
    .PS2_DATA_OE(data_oe),
    .DBG_STATE(dbg_state)
  );

  // Scoreboard
  int n_total = 0;
  int n_bad = 0;
  logic [0:0] exp_q[$];

  int         done_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         inh_mis = 0;
  logic       pulse_busy = 1'b1;
  logic [1:0] pulse_oe = 2'b11;

  always @(negedge clk) begin
    if (tx_done) begin
      done_cnt++;
      pulse_busy = tx_busy;
      pulse_oe = {clk_oe, data_oe};
    end
    if (tx_err) begin
      err_cnt++;
      pulse_busy = tx_busy;
      pulse_oe = {clk_oe, data_oe};
    end
    if (tx_done && tx_err) both_cnt++;
    if (rx_inhibit !== tx_busy) inh_mis++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] d);
    tx_data = d;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
  endtask

  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < INH + 50; i++) begin
      if (!clk_oe && data_oe) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (!ok) chk("send_entry", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic par, input bit ack_en,
                           input int glitch_at, input int start_at, input int reset_at,
                           output bit aborted);
    bit ok;
    logic [0:0] exp_b;
    aborted = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(par);
    exp_q.push_back(1'b1);
    start_tx(d);
    wait_send(ok);
    if (!ok) begin
      aborted = 1'b1;
      return;
    end
    chk("start_bit", ps2_data_in, 32'd0);
    tick(HALF);
    for (int k = 1; k <= 11; k++) begin
      model_clk = 1'b0;
      tick(HALF / 2);
      if (k == start_at) begin
        tx_data = 8'h55;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
      end else if (k == reset_at) begin
        rst_n = 1'b0;
        tick(1);
        chk("reset_mid_outputs", {tx_busy, tx_done, tx_err, rx_inhibit, clk_oe, data_oe}, 32'd0);
        chk("reset_mid_state", dbg_state, 32'd0);
        rst_n = 1'b1;
        model_clk = 1'b1;
        aborted = 1'b1;
        return;
      end else begin
        tick(1);
      end
      tick(HALF - HALF / 2 - 1);
      model_clk = 1'b1;
      if (k <= 10) begin
        exp_b = exp_q.pop_front();
        chk($sformatf("bit%0d_of_%0h", k, d), ps2_data_in, exp_b);
      end
      if (k == 10 && ack_en) model_low = 1'b1;
      if (k == 11) model_low = 1'b0;
      if (k == glitch_at) begin
        tick(20);
        glitch = 1'b1;
        tick(3);
        glitch = 1'b0;
        tick(HALF - 23);
      end else begin
        tick(HALF);
      end
    end
  endtask

  task automatic do_frame(input logic [7:0] d, input logic par, input bit ack_en,
                          input int glitch_at, input int start_at);
    int d0;
    int e0;
    bit ab;
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(d, par, ack_en, glitch_at, start_at, 0, ab);
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != d0 || err_cnt != e0) break;
      tick(1);
    end
    tick(5);
    chk($sformatf("done_pulses_%0h", d), done_cnt - d0, ack_en ? 32'd1 : 32'd0);
    chk($sformatf("err_pulses_%0h", d), err_cnt - e0, ack_en ? 32'd0 : 32'd1);
    chk("pulse_busy_low", pulse_busy, 32'd0);
    chk("pulse_lines_released", pulse_oe, 32'd0);
    chk("idle_busy", tx_busy, 32'd0);
    chk("idle_lines", {clk_oe, data_oe}, 32'd0);
    tick(20);
  endtask

  initial begin
    int d0;
    int e0;
    int len;
    bit ab;

    rst_n = 1'b0;
    tick(3);
    chk("reset_outputs", {tx_busy, tx_done, tx_err, rx_inhibit, clk_oe, data_oe}, 32'd0);
    chk("reset_state", dbg_state, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Normal frames: data, hand-computed odd parity
    do_frame(8'hED, 1'b1, 1'b1, 0, 0);
    do_frame(8'h07, 1'b0, 1'b1, 0, 0);
    do_frame(8'h00, 1'b1, 1'b1, 0, 0);
    do_frame(8'hFF, 1'b1, 1'b1, 0, 0);
    // Missing ACK
    do_frame(8'hED, 1'b1, 1'b0, 0, 0);
    // TX_START during transfer is ignored
    do_frame(8'hED, 1'b1, 1'b1, 0, 5);
    // 3-cycle clock glitch in a high phase
    do_frame(8'hA5, 1'b1, 1'b1, 3, 0);

    // Reset during bit 4, then a fresh transfer
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(8'hED, 1'b1, 1'b1, 0, 0, 4, ab);
    tick(20);
    chk("reset_no_done", done_cnt - d0, 32'd0);
    chk("reset_no_err", err_cnt - e0, 32'd0);
    do_frame(8'h3C, 1'b1, 1'b1, 0, 0);

    // Device never clocks: inhibit/request timing, then timeout
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h12);
    len = 0;
    while (clk_oe && !data_oe && len < 100) begin
      len++;
      tick(1);
    end
    chk("inhibit_len", len, INH);
    len = 0;
    while (clk_oe && data_oe && len < 10) begin
      len++;
      tick(1);
    end
    chk("req_len", len, 32'd1);
    len = 0;
    while (err_cnt == e0 && len < TO + 50) begin
      tick(1);
      len++;
    end
    chk("timeout_window", (len >= TO - 3) && (len <= TO + 5), 32'd1);
    tick(3);
    chk("timeout_err", err_cnt - e0, 32'd1);
    chk("timeout_no_done", done_cnt - d0, 32'd0);
    chk("timeout_lines", {clk_oe, data_oe}, 32'd0);
    chk("timeout_busy", tx_busy, 32'd0);

    chk("no_double_pulse", both_cnt, 32'd0);
    chk("inhibit_follows_busy", inh_mis, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same PS2_CLK/PS2_DATA pair the keyboard receiver listens on. It runs the inhibit/request-to-send sequence, shifts out data, parity and stop on device-generated clocks, and checks the device ACK. Lines are open-drain: the block only ever drives low via output enables. It asserts RX_INHIBIT so the receiver ignores bus activity while a transmission is in progress.

Parameters:
INHIBIT_CYCLES, 5000, CLK cycles PS2_CLK is held low before the request (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max CLK cycles between device clock falling edges before abort (15 ms at 50 MHz)
FILTER_LEN, 8, consecutive equal synchronized samples needed to accept a PS2_CLK level change

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET_N  in  1  synchronous reset, active low
TX_DATA  in  8  byte to send, captured when TX_START accepted
TX_START  in  1  one-cycle request; accepted only when TX_BUSY=0
TX_BUSY  out  1  high from cycle after acceptance until return to IDLE
TX_DONE  out  1  one-cycle pulse: byte sent and ACK received
TX_ERR  out  1  one-cycle pulse: timeout or missing ACK
RX_INHIBIT  out  1  equals TX_BUSY; receiver ignores the bus while high
PS2_CLK_IN  in  1  pad level of PS2_CLK
PS2_DATA_IN  in  1  pad level of PS2_DATA
PS2_CLK_OE  out  1  1 = drive PS2_CLK low, 0 = release
PS2_DATA_OE  out  1  1 = drive PS2_DATA low, 0 = release

Behaviour:
- Reset (RESET_N=0 at a CLK edge): state IDLE; all outputs 0; lines released. Reset mid-transfer releases both lines on the next edge with no TX_DONE/TX_ERR pulse.
- Inputs pass through a 2-flop synchronizer. Filtered clock changes only after FILTER_LEN equal samples. fall = filtered clock 1->0 (one-cycle strobe).
- Shift register holds {stop=1, parity, TX_DATA[7:0]}, LSB first. Parity is odd: parity = ~^TX_DATA.
- IDLE: TX_START=1 -> latch data, clear counter, go INHIBIT. TX_START while busy is ignored (no queueing).
- INHIBIT: CLK_OE=1, DATA_OE=0 for INHIBIT_CYCLES cycles, then REQ.
- REQ: CLK_OE=1, DATA_OE=1 (start bit) for 1 cycle, then SEND with CLK_OE=0, DATA_OE=1, bit counter=0, timeout counter cleared.
- SEND: on each fall, DATA_OE <= ~shift[0] and shift right; count falls 1..10 (data0..7, parity, stop). On the 10th fall, DATA_OE=0 (stop=1). Then ACK.
- ACK: on the 11th fall, sample filtered data: 0 -> WAIT_IDLE; 1 -> ERR.
- WAIT_IDLE: when filtered clock=1 and data=1, pulse TX_DONE and go IDLE.
- Timeout counter runs in SEND, ACK and WAIT_IDLE and clears on every fall. Reaching TIMEOUT_CYCLES -> ERR.
- ERR: release both lines, pulse TX_ERR for 1 cycle, go IDLE.
- TX_BUSY is 1 in every state except IDLE. TX_DONE and TX_ERR are never high in the same cycle.
- Device clocks seen during INHIBIT/REQ are ignored.

Test Plan:
- INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200, keyboard model clocks at 50-cycle half-period. Send 0xED -> DATA_OE sampled at model rising edges gives line bits 1,0,1,1,0,1,1,1, parity 1, stop 1; model ACK -> TX_DONE pulse once, TX_BUSY falls the same cycle, both OE=0.
- Send 0x07 -> parity 0; 0x00 and 0xFF -> parity 1; model checks start=0 and all 11 bits.
- Model does not drive ACK on the 11th clock -> TX_ERR pulse, no TX_DONE, lines released.
- Model never clocks after REQ -> TX_ERR exactly TIMEOUT_CYCLES after REQ exit (±sync latency), CLK_OE=DATA_OE=0.
- TX_START pulsed during transfer of 0xED -> ignored, transfer unchanged. RESET_N low during bit 4 -> next cycle all outputs 0, and a new TX_START then works.
- 3-cycle glitch on PS2_CLK_IN during SEND -> no bit advance (FILTER_LEN=8).
